// File: rtl/spi_sfr_pkg.sv
// Shared types and constants for the SPI-to-SFR responder.
package spi_sfr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StHold
  } state_e;

  localparam int unsigned CMD_W_BIT   = 7;
  localparam int unsigned CMD_RSV_MSB = 6;
  localparam int unsigned CMD_RSV_LSB = 3;
  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned CMD_BITS    = FRAME_BITS / 2;

  // Ones in the reserved command field.
  localparam logic [7:0] CMD_RSV_MASK =
      8'((8'hFF << CMD_RSV_LSB) & (8'hFF >> (7 - CMD_RSV_MSB)));

  // A command is legal only when every reserved bit is zero.
  function automatic logic cmd_rsv_ok(logic [7:0] cmd);
    return (cmd & CMD_RSV_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pad plus rise/fall detection.
module spi_pin_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;

  // Next-state of the synchronizer chain and the edge-history flop.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], d_i};
    prev_d = sync_q[SyncStages-1];
  end

  // Chain is deliberately unreset so it keeps tracking the pin through a reset;
  // a reset in mid-frame then cannot manufacture a fake edge once it releases.
  always_ff @(posedge clk_i) begin
    sync_q <= sync_d;
  end

  // Edge-history flop; cleared to 0 so no falling edge can appear out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SyncStages-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_sfr_slave.sv
// SPI mode-0 responder giving an external master read/write access to the SFRs.
module spi_sfr_slave
  import spi_sfr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scki,
  input  logic       ssn,
  input  logic       mosii,
  input  logic [7:0] sfrdatao,
  output logic       misoo,
  output logic       miso_oe,
  output logic       sfrwe,
  output logic [2:0] sfraddr_w,
  output logic [7:0] spidata_i,
  output logic [2:0] sfraddr_r,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [3:0] LastCmdBit   = 4'(CMD_BITS - 1);
  localparam logic [3:0] CmdDoneCnt   = 4'(CMD_BITS);
  localparam logic [3:0] LastFrameBit = 4'(FRAME_BITS - 1);

  logic unused_sck_lvl;
  logic sck_rise, sck_fall;
  logic ssn_sync, ssn_rise, ssn_fall;

  spi_pin_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_sck_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (scki),
    .q_o   (unused_sck_lvl),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_pin_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_ssn_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (ssn),
    .q_o   (ssn_sync),
    .rise_o(ssn_rise),
    .fall_o(ssn_fall)
  );

  // mosi needs only the synchronizer; its depth matches sck so data and clock line up.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_sync;

  // Next-state of the mosi synchronizer chain.
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosii};
  end

  // Unreset mosi synchronizer chain.
  always_ff @(posedge clk) begin
    mosi_sync_q <= mosi_sync_d;
  end

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       wr_q, wr_d;
  logic       misoo_q, misoo_d;
  logic       oe_en_q, oe_en_d;
  logic       sfrwe_q, sfrwe_d;
  logic [2:0] sfraddr_w_q, sfraddr_w_d;
  logic [7:0] spidata_q, spidata_d;
  logic [2:0] sfraddr_r_q, sfraddr_r_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] rx_next;

  assign rx_next = {rx_q[6:0], mosi_sync};

  // Frame FSM: next state, shift registers and registered SFR-side strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    wr_d         = wr_q;
    misoo_d      = misoo_q;
    oe_en_d      = 1'b1;
    sfrwe_d      = 1'b0;
    sfraddr_w_d  = sfraddr_w_q;
    spidata_d    = spidata_q;
    sfraddr_r_d  = sfraddr_r_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      StIdle: begin
        misoo_d = 1'b0;
        if (ssn_fall) begin
          state_d = StCmd;
          cnt_d   = 4'd0;
          rx_d    = 8'h00;
          tx_d    = 8'h00;
        end
      end

      StCmd: begin
        if (ssn_rise) begin
          frame_err_d = 1'b1;
          misoo_d     = 1'b0;
          state_d     = StIdle;
        end else if (cnt_q == CmdDoneCnt) begin
          // sfraddr_r settled last cycle, so sfrdatao is now the addressed register.
          tx_d    = wr_q ? 8'h00 : sfrdatao;
          state_d = StData;
        end else if (sck_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LastCmdBit) begin
            if (!cmd_rsv_ok(rx_next)) begin
              frame_err_d = 1'b1;
              misoo_d     = 1'b0;
              state_d     = StHold;
            end else begin
              sfraddr_r_d = rx_next[2:0];
              wr_d        = rx_next[CMD_W_BIT];
            end
          end
        end
      end

      StData: begin
        // Last rise wins over a coincident ssn rise: the frame is complete.
        if (sck_rise && cnt_q == LastFrameBit) begin
          if (wr_q) begin
            sfrwe_d     = 1'b1;
            sfraddr_w_d = sfraddr_r_q;
            spidata_d   = rx_next;
          end
          frame_done_d = 1'b1;
          misoo_d      = 1'b0;
          state_d      = StHold;
        end else if (ssn_rise) begin
          frame_err_d = 1'b1;
          misoo_d     = 1'b0;
          state_d     = StIdle;
        end else begin
          if (sck_fall) begin
            misoo_d = tx_q[7];
            tx_d    = {tx_q[6:0], 1'b0};
          end
          if (sck_rise) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      StHold: begin
        misoo_d = 1'b0;
        if (ssn_rise) begin
          state_d = StIdle;
        end
      end

      default: begin
        misoo_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      wr_q         <= 1'b0;
      misoo_q      <= 1'b0;
      oe_en_q      <= 1'b0;
      sfrwe_q      <= 1'b0;
      sfraddr_w_q  <= 3'd0;
      spidata_q    <= 8'h00;
      sfraddr_r_q  <= 3'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      wr_q         <= wr_d;
      misoo_q      <= misoo_d;
      oe_en_q      <= oe_en_d;
      sfrwe_q      <= sfrwe_d;
      sfraddr_w_q  <= sfraddr_w_d;
      spidata_q    <= spidata_d;
      sfraddr_r_q  <= sfraddr_r_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ssn synchronizer is unreset, so oe_en_q keeps the pad off during reset.
  assign miso_oe    = ~ssn_sync & oe_en_q;
  assign misoo      = misoo_q;
  assign sfrwe      = sfrwe_q;
  assign sfraddr_w  = sfraddr_w_q;
  assign spidata_i  = spidata_q;
  assign sfraddr_r  = sfraddr_r_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_sfr_slave.sv
// Self-checking bench for spi_sfr_slave: table of frames plus reset and back-to-back cases.
module tb_spi_sfr_slave;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       scki;
  logic       ssn;
  logic       mosii;
  logic [7:0] sfrdatao;
  logic       misoo;
  logic       miso_oe;
  logic       sfrwe;
  logic [2:0] sfraddr_w;
  logic [7:0] spidata_i;
  logic [2:0] sfraddr_r;
  logic       frame_done;
  logic       frame_err;

  always #5 clk = ~clk;

  // SFR model: combinational read of the addressed register.
  logic [7:0] sfr_mem [8];
  initial sfr_mem = '{8'h3C, 8'h11, 8'hA7, 8'h42, 8'h99, 8'hC3, 8'h0F, 8'h5E};
  assign sfrdatao = sfr_mem[sfraddr_r];

  spi_sfr_slave #(
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scki      (scki),
    .ssn       (ssn),
    .mosii     (mosii),
    .sfrdatao  (sfrdatao),
    .misoo     (misoo),
    .miso_oe   (miso_oe),
    .sfrwe     (sfrwe),
    .sfraddr_w (sfraddr_w),
    .spidata_i (spidata_i),
    .sfraddr_r (sfraddr_r),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: every sfrwe cycle must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (sfrwe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sfrwe_unexpected: got addr=%0d data=%02h, required no write",
                 sfraddr_w, spidata_i);
      end else begin
        exp_w = exp_q.pop_front();
        if ({sfraddr_w, spidata_i} !== {exp_w.addr, exp_w.data}) begin
          errors++;
          $display("FAIL sfrwe_payload: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   sfraddr_w, spidata_i, exp_w.addr, exp_w.data);
        end
      end
    end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic ssn_start();
    ssn = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  // One mode-0 bit: data set while sck low, misoo sampled just before the rise.
  task automatic send_bit(input logic b, output logic miso_b);
    mosii = b;
    repeat (4) @(negedge clk);
    miso_b = misoo;
    scki = 1'b1;
    repeat (4) @(negedge clk);
    scki = 1'b0;
  endtask

  task automatic ssn_end();
    repeat (4) @(negedge clk);
    ssn   = 1'b1;
    mosii = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                       input int extra, output logic [7:0] rd, output logic oe_seen);
    logic [15:0] word;
    logic        mb;
    word = {cmd, dat};
    rd   = 8'h00;
    ssn_start();
    oe_seen = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      send_bit(word[4'(15 - i)], mb);
      if (i >= 8) rd[3'(15 - i)] = mb;
    end
    for (int i = 0; i < extra; i++) send_bit(1'b1, mb);
    ssn_end();
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    int         nbits;
    logic       exp_we;
    logic       chk_rd;
    logic [7:0] exp_rd;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  rd;
  logic        oe_seen;
  logic [2:0]  last_addr;
  logic        mb;
  logic [15:0] word;

  initial begin
    vecs[0] = '{8'h83, 8'h5A, 16, 1'b1, 1'b1, 8'h00, 1, 0};  // write
    vecs[1] = '{8'h05, 8'h00, 16, 1'b0, 1'b1, 8'hC3, 1, 0};  // read addr 5
    vecs[2] = '{8'h81, 8'hF0, 12, 1'b0, 1'b0, 8'h00, 0, 1};  // aborted write
    vecs[3] = '{8'h82, 8'h11, 16, 1'b1, 1'b1, 8'h00, 1, 0};  // write after abort
    vecs[4] = '{8'h8B, 8'hFF, 16, 1'b0, 1'b1, 8'h00, 0, 1};  // reserved bit set
    vecs[5] = '{8'h07, 8'hAA, 16, 1'b0, 1'b1, 8'h5E, 1, 0};  // read addr 7
    vecs[6] = '{8'h00, 8'h00, 16, 1'b0, 1'b1, 8'h3C, 1, 0};  // read addr 0

    rst = 1'b1; scki = 1'b0; ssn = 1'b1; mosii = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs",
        {13'd0, misoo, miso_oe, sfrwe, sfraddr_w, spidata_i, sfraddr_r, frame_done, frame_err},
        32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    last_addr = 3'd0;

    for (int v = 0; v < 7; v++) begin
      done_cnt = 0;
      err_cnt  = 0;
      if (vecs[v].exp_we) exp_q.push_back('{addr: vecs[v].cmd[2:0], data: vecs[v].dat});
      if ((vecs[v].cmd & 8'h78) == 8'h00) last_addr = vecs[v].cmd[2:0];
      frame(vecs[v].cmd, vecs[v].dat, vecs[v].nbits, 0, rd, oe_seen);
      repeat (SS + 4) @(negedge clk);
      chk($sformatf("v%0d_done", v), done_cnt, vecs[v].exp_done);
      chk($sformatf("v%0d_err", v), err_cnt, vecs[v].exp_err);
      chk($sformatf("v%0d_writes_pending", v), exp_q.size(), 0);
      exp_q.delete();
      chk($sformatf("v%0d_sfraddr_r", v), sfraddr_r, last_addr);
      chk($sformatf("v%0d_oe_in_frame", v), oe_seen, 1'b1);
      chk($sformatf("v%0d_oe_after", v), miso_oe, 1'b0);
      if (vecs[v].chk_rd) chk($sformatf("v%0d_miso_byte", v), rd, vecs[v].exp_rd);
    end

    // Reset for one clk after bit 10 of a write; the remaining bits must be ignored.
    done_cnt = 0;
    err_cnt  = 0;
    word = 16'h8499;
    ssn_start();
    for (int i = 0; i < 10; i++) send_bit(word[4'(15 - i)], mb);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midframe_reset_outputs",
        {13'd0, misoo, miso_oe, sfrwe, sfraddr_w, spidata_i, sfraddr_r, frame_done, frame_err},
        32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 10; i < 16; i++) send_bit(word[4'(15 - i)], mb);
    ssn_end();
    repeat (SS + 4) @(negedge clk);
    chk("after_reset_done", done_cnt, 0);
    chk("after_reset_err", err_cnt, 0);
    exp_q.push_back('{addr: 3'd0, data: 8'h7E});
    frame(8'h80, 8'h7E, 16, 0, rd, oe_seen);
    repeat (SS + 4) @(negedge clk);
    chk("post_reset_done", done_cnt, 1);
    chk("post_reset_err", err_cnt, 0);
    chk("post_reset_writes_pending", exp_q.size(), 0);
    exp_q.delete();

    // Back-to-back frames, 20 extra SCK pulses each, minimum ssn-high gap.
    done_cnt = 0;
    err_cnt  = 0;
    exp_q.push_back('{addr: 3'd6, data: 8'hA5});
    exp_q.push_back('{addr: 3'd1, data: 8'h3C});
    frame(8'h86, 8'hA5, 16, 20, rd, oe_seen);
    repeat (SS + 2) @(negedge clk);
    frame(8'h81, 8'h3C, 16, 20, rd, oe_seen);
    repeat (SS + 4) @(negedge clk);
    chk("b2b_done", done_cnt, 2);
    chk("b2b_err", err_cnt, 0);
    chk("b2b_writes_pending", exp_q.size(), 0);
    chk("b2b_sfraddr_r", sfraddr_r, 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_sfr_slave.md
# spi_sfr_slave

Synchronous SPI responder that lets an external SPI master read and write the SPI block's special-function registers. It sits between the pads (scki, ssn, mosii, misoo) and the SFR port of the SPI block, and produces the same write strobe, write address, write data and read address that the on-chip CPU drives. All logic runs on the system clock. SPI pins are treated as asynchronous and oversampled; only SPI mode 0 (CPOL=0, CPHA=0), MSB first, is supported.

## Interface
- SYNC_STAGES, 2: synchronizer depth for scki, ssn and mosii; minimum 2.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- scki  in  1  SPI clock from the external master; asynchronous.
- ssn  in  1  slave select, active low; asynchronous.
- mosii  in  1  master-out data; asynchronous.
- sfrdatao  in  8  read data from the SFR block; combinational function of sfraddr_r.
- misoo  out  1  slave-out data; registered.
- miso_oe  out  1  pad enable for misoo; high while synchronized ssn is low.
- sfrwe  out  1  one-cycle SFR write strobe.
- sfraddr_w  out  3  SFR write address; valid when sfrwe is high.
- spidata_i  out  8  SFR write data; valid when sfrwe is high.
- sfraddr_r  out  3  SFR read address; held from command capture until the next command.
- frame_done  out  1  one-cycle pulse when a legal 16-bit frame completes.
- frame_err  out  1  one-cycle pulse on an aborted or illegal frame.

## Operation
- Frame is 16 SCK bits while ssn is low. Byte 0 is the command: bit 7 = W (1 write, 0 read), bits 6:3 reserved and must be 0, bits 2:0 = address. Byte 1 is write data on mosii (write), or SFR data on misoo (read).
- Front end: scki, ssn and mosii each pass through SYNC_STAGES flops; one further flop on sck and ssn gives rise/fall detection. mosii is sampled from its synchronized copy in the same cycle a rising SCK is detected.
- States: IDLE, CMD, DATA, HOLD.
  - IDLE: outputs quiet; synchronized ssn falling -> CMD, bit counter cleared, tx shift register cleared.
  - CMD: each detected SCK rise shifts mosi into rx; on the 8th rise the command is latched. Reserved bits nonzero -> pulse frame_err, go to HOLD. Otherwise sfraddr_r <= address. The next cycle, tx <= sfrdatao for reads, 0 for writes. Then -> DATA.
  - DATA: each detected SCK fall drives misoo <= tx[7] and shifts tx left. Each SCK rise shifts rx. On the 16th rise: for a write, pulse sfrwe with sfraddr_w = latched address and spidata_i = rx. For both reads and writes, pulse frame_done. Then -> HOLD.
  - HOLD: ignore further SCK edges; misoo = 0; synchronized ssn rising -> IDLE.
- ssn rising in CMD or DATA: abort. No sfrwe, pulse frame_err, go to IDLE.
- ssn rising and the 16th SCK rise detected in the same cycle: the frame completes normally (sfrwe/frame_done), with no frame_err.
- Bit counter is 4 bits. It does not wrap; it is consulted only in CMD/DATA.
- rst in any state: go to IDLE, drop any partial frame, no sfrwe, no frame_err.

## Timing
- Reset values: misoo 0, miso_oe 0, sfrwe 0, sfraddr_w 0, spidata_i 0, sfraddr_r 0, frame_done 0, frame_err 0; state IDLE.
- Pin-to-detect latency: SYNC_STAGES+1 clk for SCK/ssn edges.
- sfrwe, frame_done and frame_err are registered. Each asserts exactly one clk, in the cycle after the detection cycle.
- Read path: command latched at cycle N, sfraddr_r valid at N+1, tx loaded at N+2. The first SCK fall after the 8th rise must be detected at or after N+3.
- Minimum SCK high and low time: 4 clk. Minimum ssn-low-to-first-SCK-rise: SYNC_STAGES+2 clk. Slower SCK is always legal.
- miso_oe follows synchronized ssn. It goes high SYNC_STAGES clk after the ssn falling edge.

## Structure
- Package spi_sfr_pkg holds the state enum, CMD_W_BIT=7, CMD_RSV_MSB=6, CMD_RSV_LSB=3, FRAME_BITS=16.
- Sub-module spi_pin_sync: parameterized SYNC_STAGES synchronizer plus rise/fall detector. It is instantiated for scki and ssn; mosii uses the synchronizer only.
- Everything else is one FSM plus shift registers in spi_sfr_slave.

## Test plan
- Write frame 0x83, 0x5A with SCK high/low = 4 clk -> exactly one sfrwe pulse with sfraddr_w=3, spidata_i=0x5A; frame_done one pulse; frame_err stays 0.
- Read frame 0x05 with the SFR model returning 0xC3 for address 5 -> sfraddr_r=5; misoo bits on rises 9–16 are 1,1,0,0,0,0,1,1; no sfrwe.
- Write 0x81 then ssn deasserted after 12 bits -> no sfrwe; one frame_err pulse; state IDLE; the next frame 0x82, 0x11 writes 0x11 to address 2.
- Command 0x8B (reserved bit 3 set) followed by 0xFF -> no sfrwe, one frame_err after the 8th bit, misoo 0 for the rest of the frame.
- rst asserted for 1 clk after bit 10 of a write frame -> all outputs return to their reset values, no sfrwe; the following full frame 0x80, 0x7E writes 0x7E to address 0.
- Back-to-back frames with 20 extra SCK pulses after bit 16 and ssn high for SYNC_STAGES+2 clk between frames -> extra pulses ignored; each frame gives exactly one frame_done and the correct single write.
